// File: rtl/yuv_mb_reader.sv
// yuv_mb_reader: read-side master for the yuv_ram macroblock buffer.
// Walks word addresses 0..WORDS_PER_MB-1 for every macroblock of a frame
// and re-emits the returned words as a framed valid/ready stream. A small
// skid FIFO plus a credit check on r_ready_o absorbs the buffer's fixed
// one-cycle read latency, so downstream stalls never drop a word.
// Optional build macro MB_CHECKSUM_EN adds mb_sum, the mod-2^16 byte sum
// of the macroblock, valid together with m_eop.
module yuv_mb_reader #(
    parameter int MB_COLS      = 80,
    parameter int MB_ROWS      = 45,
    parameter int WORDS_PER_MB = 96,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [6:0]  r_addr_o,
    output logic        r_ready_o,
    input  logic        r_valid_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sop,
    output logic        m_eop,
    output logic [1:0]  m_comp,
    output logic [6:0]  mb_x,
    output logic [5:0]  mb_y,
    output logic        busy,
    output logic        frame_done
`ifdef MB_CHECKSUM_EN
    ,
    output logic [15:0] mb_sum
`endif
);

    localparam int MB_TOTAL = MB_COLS * MB_ROWS;
    localparam int CNT_W    = $clog2(MB_TOTAL + 1);
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FC_W     = $clog2(FIFO_DEPTH + 1);

    localparam logic [6:0]       LAST_ADDR = 7'(WORDS_PER_MB - 1);
    localparam logic [6:0]       Y_END     = 7'(WORDS_PER_MB * 2 / 3);
    localparam logic [6:0]       U_END     = 7'(WORDS_PER_MB * 5 / 6);
    localparam logic [6:0]       LAST_COL  = 7'(MB_COLS - 1);
    localparam logic [CNT_W-1:0] LAST_MB   = CNT_W'(MB_TOTAL - 1);
    localparam logic [FC_W-1:0]  DEPTH_C   = FC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  comp;
        logic [6:0]  x;
        logic [5:0]  y;
    } fifo_ent_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [1:0]  comp;
        logic [6:0]  x;
        logic [5:0]  y;
    } tag_t;

    // Plane of a word inside the macroblock: Y, then U, then V.
    function automatic logic [1:0] plane_of(input logic [6:0] a);
        if (a < Y_END)      return 2'd0;
        else if (a < U_END) return 2'd1;
        else                return 2'd2;
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic [6:0]       addr;
    logic [CNT_W-1:0] mb_cnt;
    logic [6:0]       rd_x;
    logic [5:0]       rd_y;
    logic             inflight;
    logic             err_flag;
    tag_t             tag_p1;

    fifo_ent_t        mem [FIFO_DEPTH];
    fifo_ent_t        head;
    fifo_ent_t        ent_in;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [FC_W-1:0]  fifo_count;

    logic             accept;
    logic             last_word;
    logic             push;
    logic             pop;
    logic             credit_ok;
    logic [FC_W:0]    credit_use;

    assign accept     = r_ready_o & r_valid_i;
    assign last_word  = (addr == LAST_ADDR);
    assign push       = data_valid_i & inflight & ((fifo_count != DEPTH_C) | pop);
    assign pop        = m_valid & m_ready;
    // The outstanding read still owns a FIFO slot until its data lands.
    assign credit_use = {1'b0, fifo_count} + (FC_W + 1)'(inflight);
    assign credit_ok  = credit_use < (FC_W + 1)'(FIFO_DEPTH);
    assign r_addr_o   = addr;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; DRAIN exits on the edge that pops the final word.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (accept && last_word && mb_cnt == LAST_MB) state_nxt = DRAIN;
            DRAIN:   if (!inflight && (fifo_count == '0 || (fifo_count == FC_W'(1) && pop)))
                         state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        r_ready_o  = (state == READ) && credit_ok;
        busy       = (state == READ) || (state == DRAIN);
        frame_done = (state == DONE);
    end

    // Read address and macroblock position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            mb_cnt <= '0;
            rd_x   <= '0;
            rd_y   <= '0;
        end else if (state == IDLE && start) begin
            addr   <= '0;
            mb_cnt <= '0;
            rd_x   <= '0;
            rd_y   <= '0;
        end else if (accept) begin
            if (last_word) begin
                addr <= '0;
                if (mb_cnt != LAST_MB) mb_cnt <= mb_cnt + CNT_W'(1);
                if (rd_x == LAST_COL) begin
                    rd_x <= '0;
                    rd_y <= rd_y + 6'd1;
                end else begin
                    rd_x <= rd_x + 7'd1;
                end
            end else begin
                addr <= addr + 7'd1;
            end
        end
    end

    // Outstanding-read flag and sticky error for unsolicited read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            inflight <= accept;
            if (data_valid_i && !inflight) err_flag <= 1'b1;
        end
    end

    // Tags captured at accept, delayed to line up with the returning data.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_p1.sop  <= (addr == 7'd0);
            tag_p1.eop  <= last_word;
            tag_p1.comp <= plane_of(addr);
            tag_p1.x    <= rd_x;
            tag_p1.y    <= rd_y;
        end
    end

    assign ent_in = '{data: data_i, sop: tag_p1.sop, eop: tag_p1.eop,
                      comp: tag_p1.comp, x: tag_p1.x, y: tag_p1.y};

    // Skid FIFO storage.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ent_in;
    end

    // Skid FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FC_W'(1);
                2'b01:   fifo_count <= fifo_count - FC_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // Stream outputs, forced to zero while the FIFO is empty.
    always_comb begin
        m_valid = (fifo_count != '0);
        m_data  = m_valid ? head.data : 32'd0;
        m_sop   = m_valid & head.sop;
        m_eop   = m_valid & head.eop;
        m_comp  = m_valid ? head.comp : 2'd0;
        mb_x    = m_valid ? head.x : 7'd0;
        mb_y    = m_valid ? head.y : 6'd0;
    end

`ifdef MB_CHECKSUM_EN
    logic [15:0] sum_acc;

    function automatic logic [15:0] byte_sum(input logic [31:0] w);
        return 16'(w[31:24]) + 16'(w[23:16]) + 16'(w[15:8]) + 16'(w[7:0]);
    endfunction

    // Running byte sum of the words already popped from this macroblock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     sum_acc <= '0;
        else if (pop)   sum_acc <= m_eop ? 16'd0 : sum_acc + byte_sum(m_data);
    end

    assign mb_sum = sum_acc + byte_sum(m_data);
`endif

    err_no_orphan_data: assert property (@(posedge clk) disable iff (!rst_n) !err_flag);

endmodule

// File: tb/tb_yuv_mb_reader.sv
// Bench for yuv_mb_reader on a 2x1 macroblock frame: a yuv_ram model
// answers reads one cycle later, and a scoreboard holds the expected
// stream words, popped as the consumer accepts them.
module tb_yuv_mb_reader;

    localparam int COLS  = 2;
    localparam int ROWS  = 1;
    localparam int WPM   = 96;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  r_addr_o;
    logic        r_ready_o;
    logic        r_valid_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic [31:0] data_i = 32'd0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_sop;
    logic        m_eop;
    logic [1:0]  m_comp;
    logic [6:0]  mb_x;
    logic [5:0]  mb_y;
    logic        busy;
    logic        frame_done;
`ifdef MB_CHECKSUM_EN
    logic [15:0] mb_sum;
`endif

    yuv_mb_reader #(
        .MB_COLS(COLS), .MB_ROWS(ROWS), .WORDS_PER_MB(WPM), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .r_addr_o(r_addr_o), .r_ready_o(r_ready_o), .r_valid_i(r_valid_i),
        .data_valid_i(data_valid_i), .data_i(data_i),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sop(m_sop), .m_eop(m_eop), .m_comp(m_comp),
        .mb_x(mb_x), .mb_y(mb_y), .busy(busy), .frame_done(frame_done)
`ifdef MB_CHECKSUM_EN
        , .mb_sum(mb_sum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  comp;
        logic [6:0]  x;
        logic [5:0]  y;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pat = 0;
    int   rdy_mode = 0;
    int   ram_mb = 0;
    int   outst = 0;
    int   pops = 0;
    int   last_pop_cyc = -1;
    int   drops = 0;
    logic [15:0] sum_exp = 16'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input int mb, input int a);
        case (pat)
            0:       return 32'(a);
            1:       return 32'h0101_0101;
            default: return {8'(mb), 8'hC3, 9'd0, 7'(a)};
        endcase
    endfunction

    function automatic logic [15:0] bsum(input logic [31:0] w);
        return 16'(w[31:24]) + 16'(w[23:16]) + 16'(w[15:8]) + 16'(w[7:0]);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // yuv_ram model: returns the addressed word one cycle after an accept.
    always @(posedge clk) begin
        data_valid_i <= rst_n && r_ready_o && r_valid_i;
        data_i       <= word_of(ram_mb, int'(r_addr_o));
        if (start) ram_mb <= 0;
        else if (r_ready_o && r_valid_i && r_addr_o == 7'(WPM - 1)) ram_mb <= ram_mb + 1;
    end

    // Downstream ready: always, ~30% random, or held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 9) < 3);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Consumer side: scoreboard compare, credit bound, checksum.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            outst = 0;
            sum_exp = 16'd0;
        end else begin
            if (r_ready_o && r_valid_i) outst++;
            if (busy && r_valid_i && !r_ready_o) drops++;
            if (m_valid && m_ready) begin
                outst--;
                pops++;
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("extra_word", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 64'(m_data), 64'(e.data));
                    chk("tags", 64'({m_sop, m_eop, m_comp, mb_x, mb_y}),
                        64'({e.sop, e.eop, e.comp, e.x, e.y}));
                    sum_exp = sum_exp + bsum(e.data);
`ifdef MB_CHECKSUM_EN
                    if (e.eop) begin
                        chk("mb_sum", 64'(mb_sum), 64'(sum_exp));
                        if (pat == 1) chk("mb_sum384", 64'(mb_sum), 64'd384);
                    end
`endif
                    if (e.eop) sum_exp = 16'd0;
                end
            end
            if (busy) chk("credit", 64'(outst <= DEPTH), 64'd1);
        end
    end

    task automatic push_frame(input int nmb);
        exp_t e;
        for (int m = 0; m < nmb; m++) begin
            for (int a = 0; a < WPM; a++) begin
                e.data = word_of(m, a);
                e.sop  = (a == 0);
                e.eop  = (a == WPM - 1);
                e.comp = (a < 64) ? 2'd0 : (a < 80) ? 2'd1 : 2'd2;
                e.x    = 7'(m % COLS);
                e.y    = 6'(m / COLS);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (frame_done) begin
                dcyc = cyc;
                return;
            end
        end
        chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic end_frame(input string tag);
        int dcyc;
        wait_done(tag, 4000, dcyc);
        if (dcyc >= 0) chk({tag, "_done_lat"}, 64'(dcyc), 64'(last_pop_cyc + 1));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(frame_done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int acc_cyc;
        int val_cyc;
        int d0;
        int p0;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", 64'({r_addr_o, r_ready_o, m_data, m_valid, m_sop, m_eop,
                                m_comp, mb_x, mb_y, busy, frame_done}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        r_valid_i = 1'b1;
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        // Test 1: word n = n, free-flowing; latency and frame_done timing
        pat = 0;
        push_frame(2);
        pulse_start();
        acc_cyc = -1;
        val_cyc = -1;
        for (int i = 0; i < 20 && acc_cyc < 0; i++) begin
            @(negedge clk);
            if (r_ready_o && r_valid_i) acc_cyc = cyc;
        end
        for (int i = 0; i < 20 && val_cyc < 0; i++) begin
            if (m_valid) val_cyc = cyc;
            else @(negedge clk);
        end
        chk("latency", 64'(val_cyc - acc_cyc), 64'd2);
        chk("busy_run", 64'(busy), 64'd1);
        end_frame("t1");

        // Test 2: random ready at ~30%
        pat = 2;
        rdy_mode = 1;
        d0 = drops;
        push_frame(2);
        pulse_start();
        end_frame("t2");
        chk("rdy_drop", 64'((drops - d0) > 0), 64'd1);
        rdy_mode = 0;

        // Test 3: r_valid_i low for 10 cycles after address 40 accepted
        push_frame(2);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (r_ready_o && r_valid_i && r_addr_o == 7'd40) seen = 1'b1;
        end
        chk("t3_saw_40", 64'(seen), 64'd1);
        @(posedge clk); #1 r_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_addr_hold", 64'(r_addr_o), 64'd41);
            if (i == 6) chk("t3_stalled", 64'(m_valid), 64'd0);
        end
        @(posedge clk); #1 r_valid_i = 1'b1;
        end_frame("t3");

        // Test 4: downstream stalled with the FIFO full
        rdy_mode = 2;
        push_frame(2);
        pulse_start();
        repeat (8) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t4_hold_data", 64'(m_data), 64'(exp_q[0].data));
            chk("t4_hold_vr", 64'({m_valid, r_ready_o}), 64'b10);
        end
        rdy_mode = 0;
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_b2b", 64'(m_valid && m_ready), 64'd1);
        end
        end_frame("t4");

        // Test 5: reset at word 50, then replay from the top
        push_frame(2);
        p0 = pops;
        pulse_start();
        for (int i = 0; i < 400 && (pops - p0) < 50; i++) @(negedge clk);
        chk("t5_reach50", 64'(pops - p0), 64'd50);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_outputs", 64'({r_addr_o, r_ready_o, m_data, m_valid, m_sop, m_eop,
                                   m_comp, mb_x, mb_y, busy, frame_done}), 64'd0);
        repeat (2) @(negedge clk);
        chk("t5_no_done", 64'(frame_done), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        push_frame(2);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        chk("t5_replay_head", 64'({m_sop, mb_x, mb_y, m_data}), 64'({1'b1, 7'd0, 6'd0, word_of(0, 0)}));
        end_frame("t5");

`ifdef MB_CHECKSUM_EN
        // Test 6: all bytes 0x01, checksum 384 per macroblock
        pat = 1;
        push_frame(2);
        pulse_start();
        end_frame("t6");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
